// File: rtl/step_sequencer.sv
// Relative-move stepper sequencer: takes a signed full-step count, walks the 4-phase
// coil table at one step per STEP_DIV clocks and keeps a wrapping absolute position.
module step_sequencer #(
  parameter int STEP_DIV = 16,
  parameter int DIV_W    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  step_count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [3:0]  coils,
  output logic [15:0] position
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic             r_dir;
  logic [8:0]       r_remaining;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_phase;

  logic [8:0]       w_sext;
  logic [8:0]       w_mag;
  logic [1:0]       w_next_phase;
  logic             w_step_edge;

  // 9-bit magnitude so that -128 yields 128 rather than overflowing
  assign w_sext       = {step_count[7], step_count};
  assign w_mag        = step_count[7] ? (~w_sext + 9'd1) : w_sext;
  assign w_next_phase = r_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);
  assign w_step_edge  = (r_div == DIV_W'(STEP_DIV - 1));

  function automatic logic [3:0] phase_pat(input logic [1:0] idx);
    case (idx)
      2'd0:    phase_pat = 4'b1100;
      2'd1:    phase_pat = 4'b0110;
      2'd2:    phase_pat = 4'b0011;
      default: phase_pat = 4'b1001;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_remaining <= '0;
      r_div       <= '0;
      r_phase     <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      coils       <= 4'b1100;
      position    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_dir       <= step_count[7];
            r_remaining <= w_mag;
            r_div       <= '0;
            if (w_mag == 9'd0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // abort wins over a step landing on the same edge
          if (abort) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (w_step_edge) begin
            r_div       <= '0;
            r_phase     <= w_next_phase;
            coils       <= phase_pat(w_next_phase);
            position    <= r_dir ? (position - 16'd1) : (position + 16'd1);
            r_remaining <= r_remaining - 9'd1;
            if (r_remaining == 9'd1) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
